pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Fetch-stage program-counter controller for the pipelined RISC-V core. It holds the architectural fetch PC, advances it by 4 each cycle, and honours hazard stalls. It consumes the branch-redirect pair (`PcSel`, `BrPC`) produced in execute, which makes it the receiving end of that interface. It also generates the pipeline flush strobes and traps permanently on an illegal redirect target.

## Interface
- `PC_W`, 9: fetch PC width in bits; instruction memory is byte-addressed over 2^PC_W bytes.
- `RESET_PC`, 0: PC value loaded on reset; must be word-aligned and < 2^PC_W.
- `clk` input 1: core clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `Stall` input 1: hazard-unit stall; hold the PC this cycle.
- `PcSel` input 1: execute-stage redirect request; 1 means the branch is taken.
- `BrPC` input 32: redirect target, valid when `PcSel`=1.
- `PC` output PC_W: current fetch address, registered.
- `IfId_Flush` output 1: squash the IF/ID register this cycle.
- `IdEx_Flush` output 1: squash the ID/EX register this cycle.
- `Trap` output 1: registered, sticky illegal-redirect indicator.
- `RedirCount` output 16: number of accepted redirects; see Configuration.

## Operation
- FSM states: RUN, TRAP. Reset state is RUN.
- Reset values: `PC`=RESET_PC, `Trap`=0, `RedirCount`=0. Flush outputs are 0 while `reset` is low.
- A redirect is legal when `BrPC[1:0]`==0 and `BrPC[31:PC_W]`==0.
- RUN, priority order:
  1. `PcSel`=1 and target legal: `PC`<=`BrPC[PC_W-1:0]`. Assert `IfId_Flush`=`IdEx_Flush`=1 combinationally in the same cycle. Increment `RedirCount`.
  2. `PcSel`=1 and target illegal: `PC` holds. Go to TRAP. `Trap`<=1. Assert both flushes this cycle.
  3. `Stall`=1: `PC` holds. No flush.
  4. Otherwise: `PC`<=`PC`+4, computed modulo 2^PC_W.
- A redirect overrides `Stall` in the same cycle. Stalling on a taken branch would re-execute wrong-path work.
- TRAP: `PC` is frozen and `Trap`=1. Both flushes are held at 1 every cycle. `PcSel` and `Stall` are ignored. Only `reset` exits TRAP.
- Arithmetic: the increment is PC_W bits wide and the carry is discarded. For example, PC_W=9 with `PC`=0x1FC gives next `PC`=0x000.
- Flush outputs are purely combinational from state, `PcSel`, and the legality check. They carry no registered delay.

## Timing
- Redirect latency: `PcSel` sampled high at edge N gives `PC`=target after edge N. Flushes are high during the cycle before edge N.
- Stall latency: zero. `PC` is unchanged across any edge where `Stall`=1.
- Back-to-back redirects on consecutive cycles are each accepted. Each one flushes and increments the count.
- Reset asserted mid-operation forces the reset values immediately, with no clock needed. This applies from either state and discards any pending redirect.
- Reset deassertion is synchronous to `clk` at system level. The first edge after release performs a normal RUN update.

## Configuration
- Macro `PC_REDIRECT_STATS_EN`.
- Defined: `RedirCount` is a 16-bit counter incremented on each legal accepted redirect. It saturates at 0xFFFF and does not wrap. It resets to 0.
- Not defined: the counter register is not built and `RedirCount` is tied to 16'h0000. All other behaviour is identical.

## Test plan
- Reset then 4 free-running cycles with `Stall`=0 and `PcSel`=0 -> `PC` sequence 0x000, 0x004, 0x008, 0x00C, 0x010; flushes stay 0.
- `PC`=0x010 with `Stall`=1 for 3 cycles, then released -> `PC` holds 0x010 for 3 edges, then 0x014; no flush asserted.
- `PcSel`=1, `BrPC`=0x0000_0040 with `Stall`=1 in the same cycle -> both flushes high that cycle; next `PC`=0x040; `RedirCount`=1 (with macro) or 0 (without).
- Wrap: `PC`=0x1FC, no stall -> next `PC`=0x000.
- Illegal targets: `BrPC`=0x0000_0042 (misaligned) -> `Trap`=1, `PC` frozen, flushes held high. After reset, `BrPC`=0x0000_0200 (out of range for PC_W=9) -> same trap response.
- Async reset pulsed mid-cycle while in TRAP -> `PC`=0x000, `Trap`=0, flushes 0 without waiting for a clock edge; normal increment resumes after release.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-PC controller bus: hazard/execute inputs and fetch-side outputs.
// Latency: none. Wires only, with no state.
// Backpressure: none. Stall is a plain level, not a handshake.
// Signals:
//   Stall, PcSel, BrPC                         : toward the controller
//   PC, IfId_Flush, IdEx_Flush, Trap, RedirCount : from the controller
// master = hazard unit / execute stage (driver side)
// slave  = pc_fetch_ctrl (receiving end of the redirect pair)
interface pc_fetch_ctrl_if #(
  parameter int unsigned PC_W = 9
);
  logic            Stall;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic [PC_W-1:0] PC;
  logic            IfId_Flush;
  logic            IdEx_Flush;
  logic            Trap;
  logic [15:0]     RedirCount;

  modport master (
    output Stall, PcSel, BrPC,
    input  PC, IfId_Flush, IdEx_Flush, Trap, RedirCount
  );

  modport slave (
    input  Stall, PcSel, BrPC,
    output PC, IfId_Flush, IdEx_Flush, Trap, RedirCount
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC controller: +4 advance, stall hold, branch redirect, flushes, sticky trap on bad target.
// Latency: PC/Trap/RedirCount registered (1 edge); flushes combinational in the redirect cycle.
// Backpressure: Stall holds the PC; a redirect overrides Stall; the TRAP state ignores all inputs.
// Ports:
//   clk   : core clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : pc_fetch_ctrl_if.slave
//           in:  Stall, PcSel, BrPC
//           out: PC, IfId_Flush, IdEx_Flush, Trap, RedirCount
// Optional feature macro: PC_REDIRECT_STATS_EN. It builds a saturating 16-bit redirect counter.
// When the macro is undefined, RedirCount is tied to zero.
module pc_fetch_ctrl #(
  parameter int unsigned     PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  pc_fetch_ctrl_if.slave  bus
);

  typedef enum logic {RUN, TRAP} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            trap_q, trap_d;
  logic            tgt_legal;
  logic            redir_accept;
  logic            flush;

  // Target must be word-aligned and fit inside the 2^PC_W byte window.
  assign tgt_legal    = (bus.BrPC[1:0] == 2'b00) && ((bus.BrPC >> PC_W) == 32'd0);
  assign redir_accept = (state_q == RUN) && bus.PcSel && tgt_legal;

  // Both legal and illegal redirects squash the younger stages.
  // The TRAP state keeps them squashed. The flushes are gated off while reset is held.
  assign flush = reset && ((state_q == TRAP) || bus.PcSel);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    trap_d  = trap_q;
    unique case (state_q)
      RUN: begin
        if (bus.PcSel) begin
          if (tgt_legal) begin
            pc_d = bus.BrPC[PC_W-1:0];
          end else begin
            state_d = TRAP;
            trap_d  = 1'b1;
          end
        end else if (!bus.Stall) begin
          pc_d = pc_q + PC_W'(4);  // carry out of PC_W bits is dropped
        end
      end
      TRAP: begin
        // Frozen until reset.
      end
      default: begin
        state_d = TRAP;
        trap_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      trap_q  <= trap_d;
    end
  end

`ifdef PC_REDIRECT_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (redir_accept && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.RedirCount = cnt_q;
`else
  logic unused_accept;
  assign unused_accept  = redir_accept;
  assign bus.RedirCount = 16'h0000;
`endif

  assign bus.PC         = pc_q;
  assign bus.Trap       = trap_q;
  assign bus.IfId_Flush = flush;
  assign bus.IdEx_Flush = flush;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl.
// It applies a table of directed vectors and some hand-written reset sequences.
// It then applies random stimulus and compares against a reference model.
// Ports: none. It drives pc_fetch_ctrl_if.master.
module tb_pc_fetch_ctrl;
  localparam int unsigned PC_W  = 9;
  localparam int unsigned PC_SZ = 1 << PC_W;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  pc_fetch_ctrl_if #(.PC_W(PC_W)) bus ();

  pc_fetch_ctrl #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, kept as plain integers.
  int unsigned m_pc;
  bit          m_trap;
  int unsigned m_cnt;

  function automatic int unsigned cnt_expect(input int unsigned c);
`ifdef PC_REDIRECT_STATS_EN
    return c;
`else
    return (c == 0) ? 0 : 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1. Checks the flushes mid-cycle and the registered outputs after the edge.
  task automatic apply(input string name, input bit stall, input bit pcsel, input logic [31:0] brpc,
                       input bit e_flush, input int unsigned e_pc, input bit e_trap,
                       input int unsigned e_cnt);
    bus.Stall = stall;
    bus.PcSel = pcsel;
    bus.BrPC  = brpc;
    @(negedge clk);
    chk({name, ".ifid_flush"}, 32'(bus.IfId_Flush), 32'(e_flush));
    chk({name, ".idex_flush"}, 32'(bus.IdEx_Flush), 32'(e_flush));
    @(posedge clk);
    #1;
    chk({name, ".pc"},   32'(bus.PC),         e_pc);
    chk({name, ".trap"}, 32'(bus.Trap),       32'(e_trap));
    chk({name, ".cnt"},  32'(bus.RedirCount), cnt_expect(e_cnt));
  endtask

  // Asserts reset asynchronously mid-cycle and checks the outputs before any edge.
  // Reset is released at posedge+1.
  task automatic async_reset(input string name);
    bus.PcSel = 1'b1;  // a pending redirect must be discarded
    bus.BrPC  = 32'h0000_0080;
    #2;
    reset = 1'b0;
    #1;
    chk({name, ".pc"},    32'(bus.PC),         32'h0);
    chk({name, ".trap"},  32'(bus.Trap),       32'h0);
    chk({name, ".flush"}, 32'(bus.IfId_Flush | bus.IdEx_Flush), 32'h0);
    chk({name, ".cnt"},   32'(bus.RedirCount), 32'h0);
    @(posedge clk);
    #1;
    chk({name, ".pc_held"}, 32'(bus.PC), 32'h0);
    bus.PcSel = 1'b0;
    bus.BrPC  = '0;
    reset     = 1'b1;
    m_pc = 0; m_trap = 0; m_cnt = 0;
  endtask

  // Model step, derived from the rules rather than from the RTL structure.
  task automatic model_step(input bit stall, input bit pcsel, input logic [31:0] brpc,
                            output bit flush);
    flush = m_trap || pcsel;
    if (m_trap) return;
    if (pcsel) begin
      if ((brpc % 4 == 0) && (brpc < PC_SZ)) begin
        m_pc = brpc;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_trap = 1;
      end
    end else if (!stall) begin
      m_pc = (m_pc + 4) % PC_SZ;
    end
  endtask

  typedef struct {
    string       name;
    bit          stall;
    bit          pcsel;
    logic [31:0] brpc;
    bit          e_flush;
    int unsigned e_pc;
    bit          e_trap;
    int unsigned e_cnt;
  } vec_t;

  vec_t vecs[15];

  initial begin
    bit f;
    logic [31:0] t;
    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{"run1",    0, 0, 32'h0,   0, 32'h004, 0, 0};
    vecs[1]  = '{"run2",    0, 0, 32'h0,   0, 32'h008, 0, 0};
    vecs[2]  = '{"run3",    0, 0, 32'h0,   0, 32'h00C, 0, 0};
    vecs[3]  = '{"run4",    0, 0, 32'h0,   0, 32'h010, 0, 0};
    vecs[4]  = '{"stall1",  1, 0, 32'h0,   0, 32'h010, 0, 0};
    vecs[5]  = '{"stall2",  1, 0, 32'h0,   0, 32'h010, 0, 0};
    vecs[6]  = '{"stall3",  1, 0, 32'h0,   0, 32'h010, 0, 0};
    vecs[7]  = '{"release", 0, 0, 32'h0,   0, 32'h014, 0, 0};
    vecs[8]  = '{"br_stall",1, 1, 32'h40,  1, 32'h040, 0, 1};
    vecs[9]  = '{"br_b2b",  0, 1, 32'h1FC, 1, 32'h1FC, 0, 2};
    vecs[10] = '{"wrap",    0, 0, 32'h0,   0, 32'h000, 0, 2};
    vecs[11] = '{"misalign",0, 1, 32'h42,  1, 32'h000, 1, 2};
    vecs[12] = '{"trap_hold",0,0, 32'h0,   1, 32'h000, 1, 2};
    vecs[13] = '{"trap_ign",1, 1, 32'h80,  1, 32'h000, 1, 2};
    vecs[14] = '{"trap_ign2",0,1, 32'h4,   1, 32'h000, 1, 2};

    // Reset state. A redirect is driven during reset, and the flushes must stay low.
    reset     = 1'b0;
    bus.Stall = 1'b0;
    bus.PcSel = 1'b1;
    bus.BrPC  = 32'h40;
    #12;
    chk("rst.pc",    32'(bus.PC),         32'h0);
    chk("rst.trap",  32'(bus.Trap),       32'h0);
    chk("rst.flush", 32'(bus.IfId_Flush | bus.IdEx_Flush), 32'h0);
    chk("rst.cnt",   32'(bus.RedirCount), 32'h0);
    bus.PcSel = 1'b0;
    bus.BrPC  = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    foreach (vecs[i])
      apply(vecs[i].name, vecs[i].stall, vecs[i].pcsel, vecs[i].brpc,
            vecs[i].e_flush, vecs[i].e_pc, vecs[i].e_trap, vecs[i].e_cnt);

    // Async reset out of TRAP, then normal increment resumes.
    async_reset("rst_trap");
    apply("resume", 0, 0, 32'h0, 0, 32'h004, 0, 0);

    // Out-of-range target traps the same way.
    apply("oor",      0, 1, 32'h200, 1, 32'h004, 1, 0);
    apply("oor_hold", 0, 0, 32'h0,   1, 32'h004, 1, 0);
    async_reset("rst_oor");

    // Random stimulus against the model.
    for (int n = 0; n < 400; n++) begin
      bit st, ps;
      if (m_trap && ($urandom_range(0, 3) == 0)) begin
        async_reset("rnd_rst");
        continue;
      end
      st = ($urandom_range(0, 3) == 0);
      ps = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0) t = $urandom();
      else t = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
      model_step(st, ps, t, f);
      apply("rnd", st, ps, t, f, m_pc, m_trap, m_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
